// File: rtl/td4_pkg.sv
// td4_pkg
//   Shared constants and the loader state type for the TD4 writable program
//   store. Imported by prog_mem and prog_loader.
//   Related build macro: PROG_LOADER_CHECKSUM_EN (see prog_loader.sv).
package td4_pkg;

  localparam int TD4_DEPTH  = 16;
  localparam int TD4_ADDR_W = 4;
  localparam int TD4_DATA_W = 8;

  // Explicit 3-bit encodings so the state vector stays stable across builds,
  // whether or not the CHECK state is reachable.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } loader_state_t;

endpackage

// File: rtl/prog_mem.sv
// prog_mem
//   DEPTH x DATA_W instruction register file for the TD4 core.
//   Ports:
//     clk      - write clock, rising edge
//     n_reset  - asynchronous active-low clear; every word returns to 0x00 (nop)
//     we       - write enable
//     waddr    - write address
//     wdata    - write data
//     raddr    - combinational read address (CPU fetch)
//     rdata    - word at raddr, combinational
module prog_mem
  import td4_pkg::*;
#(
  parameter int DEPTH  = TD4_DEPTH,
  parameter int ADDR_W = TD4_ADDR_W,
  parameter int DATA_W = TD4_DATA_W
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] word_rd [DEPTH];

  // One register per word: the asynchronous clear rules out a RAM macro, and
  // keeping each word in its own block gives every register a single driver.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
      logic [DATA_W-1:0] word_reg;

      always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
          word_reg <= '0;
        end else if (we && (waddr == ADDR_W'(gi))) begin
          word_reg <= wdata;
        end
      end

      assign word_rd[gi] = word_reg;
    end
  endgenerate

  assign rdata = word_rd[raddr];

endmodule

// File: rtl/prog_loader.sv
// prog_loader
//   Write side of the TD4 16x8 program store. Accepts a byte stream over a
//   valid/ready handshake, writes it to addresses 0..DEPTH-1 in order and holds
//   the CPU in reset until a complete image is present.
//   Build macro: PROG_LOADER_CHECKSUM_EN - when defined, a checksum byte
//   (8-bit sum of the image) follows the image and a mismatch ends in ERR.
//   Ports:
//     clk, n_reset  - clock (rising edge), asynchronous active-low reset
//     start         - single-cycle request to begin a (re)load
//     in_valid      - load byte valid
//     in_data       - load byte
//     in_ready      - loader accepts a byte this cycle (registered)
//     address       - CPU fetch address
//     data          - instruction at address, combinational
//     cpu_hold      - keep CPU in reset while high
//     load_done     - complete valid image present
//     load_err      - last load failed its checksum
//     load_count    - image bytes accepted in current/last load (0..DEPTH)
module prog_loader
  import td4_pkg::*;
#(
  parameter int DEPTH  = TD4_DEPTH,
  parameter int ADDR_W = TD4_ADDR_W,
  parameter int DATA_W = TD4_DATA_W
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   load_count
);

  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

  loader_state_t   state_reg, state_next;
  logic [ADDR_W:0] count_reg, count_next;
  logic            in_ready_reg;
  logic            xfer;
  logic            we;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_reg, sum_next;
`endif

  assign xfer = in_valid && in_ready_reg;

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    we         = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
    sum_next   = sum_reg;
`endif
    case (state_reg)
      IDLE, DONE, ERR: begin
        // Memory is deliberately left intact: the old image stays readable
        // until it is overwritten byte by byte.
        if (start) begin
          state_next = LOAD;
          count_next = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_next   = '0;
`endif
        end
      end
      LOAD: begin
        // The count bound makes a 17th write impossible even if the state
        // register were ever corrupted.
        if (xfer && (count_reg <= LAST_IDX)) begin
          we         = 1'b1;
          count_next = count_reg + (ADDR_W+1)'(1);
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_next   = sum_reg + in_data;
          if (count_reg == LAST_IDX) state_next = CHECK;
`else
          if (count_reg == LAST_IDX) state_next = DONE;
`endif
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      CHECK: begin
        // Checksum byte is consumed but never written to memory.
        if (xfer) state_next = (in_data == sum_reg) ? DONE : ERR;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      in_ready_reg <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_reg      <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      // Registered from the next state so in_ready tracks the state with no
      // combinational path from in_valid.
      in_ready_reg <= (state_next == LOAD) || (state_next == CHECK);
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_reg      <= sum_next;
`endif
    end
  end

  prog_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk     (clk),
    .n_reset (n_reset),
    .we      (we),
    .waddr   (count_reg[ADDR_W-1:0]),
    .wdata   (in_data),
    .raddr   (address),
    .rdata   (data)
  );

  assign in_ready   = in_ready_reg;
  assign cpu_hold   = (state_reg != DONE);
  assign load_done  = (state_reg == DONE);
`ifdef PROG_LOADER_CHECKSUM_EN
  assign load_err   = (state_reg == ERR);
`else
  assign load_err   = 1'b0;
`endif
  assign load_count = count_reg;

endmodule
